// File: rtl/fds_line_packer.sv
// Frames the dark-subtracted float pixel stream into PC messages (header, pixels, line/frame trailers).
// Pixels are buffered in an internal FIFO so PC back-pressure never stalls the pixel stream; loss is flagged.
module fds_line_packer #(
    parameter int XB_SIZE   = 32,
    parameter int FP_SIZE   = 32,
    parameter int FIFO_LOG2 = 11
) (
    input  logic               pixel_clk,
    input  logic               reset_n,
    input  logic               fds_val,
    input  logic [FP_SIZE-1:0] fds,
    input  logic               fval,
    input  logic               lval,
    input  logic               fpga_msg_full,
    output logic               fpga_msg_valid,
    output logic [XB_SIZE-1:0] fpga_msg,
    output logic               error
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int EW    = FP_SIZE + 2;
    localparam logic [1:0] K_PIX = 2'd0;
    localparam logic [1:0] K_EOL = 2'd1;
    localparam logic [1:0] K_EOF = 2'd2;
    localparam logic [FIFO_LOG2:0] PTR_ONE = {{FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_LOG2:0] PTR_WRAP = {1'b1, {FIFO_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_FTRL} state_e;

    logic lval_q, fval_q, eof_pend_q, eof_pend_d;
    logic eol_ev, eof_ev, wr_req, collide, wr_ok, drop, pop;
    logic [EW-1:0] wr_ent, head;
    logic [EW-1:0] mem [DEPTH];
    logic [FIFO_LOG2:0] wr_ptr_q, rd_ptr_q;
    logic fifo_empty, fifo_full;
    logic [1:0] head_kind;

    state_e state_q, state_d;
    logic [15:0] row_q, pix_cnt_q;
    logic [23:0] frame_q;
    logic ovf_line_q, error_q, vld_q, vld_d;
    logic [XB_SIZE-1:0] msg_q, msg_d;
    logic go, avail, cnt_inc, row_inc, trl_clr, frame_done;

    // A simultaneous EOL/EOF writes EOL now and parks EOF for the following cycle.
    always_comb begin
        eol_ev     = lval_q & ~lval;
        eof_ev     = fval_q & ~fval;
        wr_req     = 1'b0;
        wr_ent     = '0;
        eof_pend_d = 1'b0;
        collide    = 1'b0;
        if (eof_pend_q) begin
            wr_req  = 1'b1;
            wr_ent  = {K_EOF, {FP_SIZE{1'b0}}};
            collide = fds_val | eol_ev | eof_ev;
        end else if (fds_val) begin
            wr_req = 1'b1;
            wr_ent = {K_PIX, fds};
        end else if (eol_ev) begin
            wr_req     = 1'b1;
            wr_ent     = {K_EOL, {FP_SIZE{1'b0}}};
            eof_pend_d = eof_ev;
        end else if (eof_ev) begin
            wr_req = 1'b1;
            wr_ent = {K_EOF, {FP_SIZE{1'b0}}};
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_WRAP);
    assign head       = mem[rd_ptr_q[FIFO_LOG2-1:0]];
    assign head_kind  = head[EW-1:FP_SIZE];
    assign wr_ok      = wr_req & (~fifo_full | pop);
    assign drop       = (wr_req & ~wr_ok) | collide;
    assign go         = ~fpga_msg_full;
    assign avail      = ~fifo_empty;

    always_ff @(posedge pixel_clk) begin
        if (wr_ok) mem[wr_ptr_q[FIFO_LOG2-1:0]] <= wr_ent;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go && avail && head_kind == K_PIX) state_d = S_DATA;
            S_DATA: if (go && avail) begin
                if (head_kind == K_EOL)      state_d = S_IDLE;
                else if (head_kind != K_PIX) state_d = S_FTRL;
            end
            S_FTRL: if (go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The first pixel of a line stays in the FIFO while its header goes out.
    always_comb begin
        pop = 1'b0; vld_d = 1'b0; msg_d = msg_q;
        cnt_inc = 1'b0; row_inc = 1'b0; trl_clr = 1'b0; frame_done = 1'b0;
        case (state_q)
            S_IDLE: if (go && avail) begin
                vld_d = 1'b1;
                msg_d = '0;
                if (head_kind == K_PIX) begin
                    msg_d[31:0] = {row_q, frame_q[11:0], 4'hA};
                end else if (head_kind == K_EOL) begin
                    pop = 1'b1; trl_clr = 1'b1;
                    msg_d[31:0] = {pix_cnt_q, 11'd0, ovf_line_q, 4'hE};
                end else begin
                    pop = 1'b1; frame_done = 1'b1;
                    msg_d[31:0] = {frame_q, 4'h0, 4'hF};
                end
            end
            S_DATA: if (go && avail) begin
                pop = 1'b1; vld_d = 1'b1;
                msg_d = '0;
                if (head_kind == K_PIX) begin
                    cnt_inc = 1'b1;
                    msg_d[FP_SIZE-1:0] = head[FP_SIZE-1:0];
                end else begin
                    trl_clr = 1'b1;
                    row_inc = (head_kind == K_EOL);
                    msg_d[31:0] = {pix_cnt_q, 11'd0, ovf_line_q, 4'hE};
                end
            end
            S_FTRL: if (go) begin
                vld_d = 1'b1; frame_done = 1'b1;
                msg_d = '0;
                msg_d[31:0] = {frame_q, 4'h0, 4'hF};
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            lval_q <= 1'b0; fval_q <= 1'b0; eof_pend_q <= 1'b0;
            wr_ptr_q <= '0; rd_ptr_q <= '0;
            row_q <= '0; pix_cnt_q <= '0; frame_q <= '0;
            ovf_line_q <= 1'b0; error_q <= 1'b0;
            vld_q <= 1'b0; msg_q <= '0;
        end else begin
            lval_q     <= lval;
            fval_q     <= fval;
            eof_pend_q <= eof_pend_d;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (frame_done)   row_q <= '0;
            else if (row_inc) row_q <= row_q + 16'd1;
            if (trl_clr)      pix_cnt_q <= '0;
            else if (cnt_inc) pix_cnt_q <= pix_cnt_q + 16'd1;
            if (frame_done) frame_q <= frame_q + 24'd1;
            // A drop belongs to a line still being written, so it beats the clear.
            if (drop)         ovf_line_q <= 1'b1;
            else if (trl_clr) ovf_line_q <= 1'b0;
            if (drop) error_q <= 1'b1;
            vld_q <= vld_d;
            msg_q <= msg_d;
        end
    end

    assign fpga_msg_valid = vld_q;
    assign fpga_msg       = msg_q;
    assign error          = error_q;
endmodule

// File: tb/tb_fds_line_packer.sv
// Bench for fds_line_packer: directed and random frames against an event-level message model.
module tb_fds_line_packer;
    localparam int XB = 32;
    localparam int FP = 32;
    localparam int L2 = 3;

    logic pixel_clk = 1'b0;
    logic reset_n, fds_val, fval, lval, fpga_msg_full;
    logic [FP-1:0] fds;
    logic fpga_msg_valid, error;
    logic [XB-1:0] fpga_msg;

    always #5 pixel_clk = ~pixel_clk;

    fds_line_packer #(.XB_SIZE(XB), .FP_SIZE(FP), .FIFO_LOG2(L2)) dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .fds_val(fds_val), .fds(fds),
        .fval(fval), .lval(lval), .fpga_msg_full(fpga_msg_full),
        .fpga_msg_valid(fpga_msg_valid), .fpga_msg(fpga_msg), .error(error)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    int m_row, m_frame, m_cnt, cap, kept;
    bit m_ovf, m_inl, prev_l, prev_f, rf_last;
    logic [31:0] last_e;

    function automatic void m_reset();
        m_row = 0; m_frame = 0; m_cnt = 0; m_ovf = 0; m_inl = 0; kept = 0;
        exp_q.delete();
    endfunction

    // cap >= 0 models a sink held full from an empty FIFO: only cap entries fit.
    function automatic bit m_room();
        if (cap < 0) return 1'b1;
        if (kept < cap) begin kept++; return 1'b1; end
        m_ovf = 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_pix(input logic [31:0] d);
        if (!m_room()) return;
        if (!m_inl) begin
            exp_q.push_back({m_row[15:0], m_frame[11:0], 4'hA});
            m_inl = 1'b1;
        end
        exp_q.push_back(d);
        m_cnt++;
    endfunction

    function automatic void m_eol();
        if (!m_room()) return;
        exp_q.push_back({m_cnt[15:0], 11'd0, m_ovf, 4'hE});
        if (m_inl) m_row++;
        m_cnt = 0; m_ovf = 1'b0; m_inl = 1'b0;
    endfunction

    function automatic void m_eof();
        if (!m_room()) return;
        if (m_inl) begin
            exp_q.push_back({m_cnt[15:0], 11'd0, m_ovf, 4'hE});
            m_cnt = 0; m_ovf = 1'b0; m_inl = 1'b0;
        end
        exp_q.push_back({m_frame[23:0], 4'h0, 4'hF});
        m_frame++;
        m_row = 0;
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input bit f, input bit l, input bit fu);
        fds_val = v; fds = v ? d : '0; fval = f; lval = l; fpga_msg_full = fu;
        if (v) m_pix(d);
        if (prev_l && !l) m_eol();
        if (prev_f && !f) m_eof();
        prev_l = l; prev_f = f;
        @(negedge pixel_clk);
    endtask

    task automatic rstep(input bit v, input logic [31:0] d, input bit f, input bit l);
        bit fu;
        fu = !rf_last && ($urandom_range(0, 2) == 0);
        rf_last = fu;
        step(v, d, f, l, fu);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            step(1'b0, 32'h0, prev_f, prev_l, 1'b0);
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++; $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
        end
        repeat (4) step(1'b0, 32'h0, prev_f, prev_l, 1'b0);
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(posedge pixel_clk);
            #1;
            if (reset_n === 1'b1 && fpga_msg_valid === 1'b1) begin
                total++;
                assert (fpga_msg_full === 1'b0) else begin
                    bad++; $error("FAIL valid_while_full observed=%b expected=0", fpga_msg_full);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $error("FAIL extra_word observed=%h expected=none", fpga_msg);
                end else begin
                    e = exp_q.pop_front();
                    assert (fpga_msg === e) else begin
                        bad++; $error("FAIL msg_word observed=%h expected=%h", fpga_msg, e);
                    end
                end
                if (fpga_msg[3:0] == 4'hE) last_e = fpga_msg;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; fds_val = 1'b0; fds = '0; fval = 1'b0; lval = 1'b0; fpga_msg_full = 1'b0;
        prev_l = 1'b0; prev_f = 1'b0; rf_last = 1'b0; cap = -1; last_e = '0;
        m_reset();
        fork monitor(); join_none
        repeat (2) @(negedge pixel_clk);
        total++; assert (fpga_msg_valid === 1'b0) else begin bad++; $error("FAIL rst_valid observed=%b expected=0", fpga_msg_valid); end
        total++; assert (fpga_msg === 32'h0) else begin bad++; $error("FAIL rst_msg observed=%h expected=0", fpga_msg); end
        total++; assert (error === 1'b0) else begin bad++; $error("FAIL rst_error observed=%b expected=0", error); end
        reset_n = 1'b1;
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Two rows of four pixels, open sink.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 32'h3F800000 + 32'(r * 4 + i), 1'b1, 1'b1, 1'b0);
            repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain(50);
        total++; assert (last_e === 32'h0004_000E) else begin bad++; $error("FAIL t1_trailer observed=%h expected=0004000e", last_e); end

        // Sink full for 20 cycles mid-row with sparse pixels: nothing lost.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 96; c++)
            step(c % 4 == 0, 32'h4000_0000 + 32'(c), 1'b1, 1'b1, c >= 20 && c < 40);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain(80);
        total++; assert (error === 1'b0) else begin bad++; $error("FAIL t2_error observed=%b expected=0", error); end

        // lval and fval fall together.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h5000_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain(40);
        total++; assert (last_e === 32'h0005_000E) else begin bad++; $error("FAIL t4_trailer observed=%h expected=0005000e", last_e); end

        // Random frames; sink full never two cycles in a row so the FIFO cannot overflow.
        for (int fr = 0; fr < 6; fr++) begin
            int nrows;
            bit together;
            nrows = $urandom_range(1, 3);
            together = 1'b0;
            rstep(1'b0, 32'h0, 1'b1, 1'b0);
            for (int r = 0; r < nrows; r++) begin
                int n;
                n = $urandom_range(0, 10);
                rstep(1'b0, 32'h0, 1'b1, 1'b1);
                for (int i = 0; i < n; i++) begin
                    rstep(1'b1, $urandom, 1'b1, 1'b1);
                    repeat ($urandom_range(1, 3)) rstep(1'b0, 32'h0, 1'b1, 1'b1);
                end
                if (r == nrows - 1 && $urandom_range(0, 1) == 1) begin
                    together = 1'b1;
                    rstep(1'b0, 32'h0, 1'b0, 1'b0);
                end else begin
                    repeat ($urandom_range(4, 6)) rstep(1'b0, 32'h0, 1'b1, 1'b0);
                end
            end
            if (!together) rstep(1'b0, 32'h0, 1'b0, 1'b0);
            repeat (5) rstep(1'b0, 32'h0, 1'b0, 1'b0);
        end
        drain(200);
        total++; assert (error === 1'b0) else begin bad++; $error("FAIL rnd_error observed=%b expected=0", error); end

        // 16-pixel row into an 8-deep FIFO with the sink held full: half the row and its EOL are lost.
        cap = 8; kept = 0;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cap = -1;
        drain(40);
        total++; assert (error === 1'b1) else begin bad++; $error("FAIL t3_error observed=%b expected=1", error); end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain(40);
        total++; assert (last_e === 32'h0008_001E) else begin bad++; $error("FAIL t3_trailer observed=%h expected=0008001e", last_e); end

        // Reset mid-row: outputs clear at once, partial line discarded.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h6000_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
        reset_n = 1'b0; fds_val = 1'b0; fval = 1'b0; lval = 1'b0;
        prev_l = 1'b0; prev_f = 1'b0;
        m_reset();
        #1;
        total++; assert (fpga_msg_valid === 1'b0) else begin bad++; $error("FAIL t5_valid observed=%b expected=0", fpga_msg_valid); end
        total++; assert (fpga_msg === 32'h0) else begin bad++; $error("FAIL t5_msg observed=%h expected=0", fpga_msg); end
        total++; assert (error === 1'b0) else begin bad++; $error("FAIL t5_error observed=%b expected=0", error); end
        @(negedge pixel_clk);
        reset_n = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 32'h7000_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain(40);

        // 65537-pixel line: pixel count wraps to 1.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) step(1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain(100);
        total++; assert (last_e === 32'h0001_000E) else begin bad++; $error("FAIL t6_wrap observed=%h expected=0001000e", last_e); end
        total++; assert (error === 1'b0) else begin bad++; $error("FAIL t6_error observed=%b expected=0", error); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
